traffic_phase_scheduler: RTL

//  Sequences the two-road intersection: owns the phase FSM, the per-phase countdown and

---
 rtl/traffic_pkg.sv | 73 +++++++
 rtl/phase_timer.sv | 43 ++++
 rtl/traffic_phase_scheduler.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the intersection scheduler: phase codes, default durations and lamp decode.
package traffic_pkg;

    typedef enum logic [2:0] {
        AR2   = 3'd0,
        G1    = 3'd1,
        Y1    = 3'd2,
        AR1   = 3'd3,
        G2    = 3'd4,
        Y2    = 3'd5,
        FLASH = 3'd6
    } phase_e;

    localparam int DEF_CNT_W    = 5;
    localparam int DEF_GREEN_T  = 25;
    localparam int DEF_YELLOW_T = 5;
    localparam int DEF_ALLRED_T = 1;
    localparam int DEF_PED_MIN  = 5;

    typedef struct packed {
        logic r1;
        logic y1;
        logic g1;
        logic r2;
        logic y2;
        logic g2;
    } lamps_t;

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            AR2:     return G1;
            G1:      return Y1;
            Y1:      return AR1;
            AR1:     return G2;
            G2:      return Y2;
            default: return AR2;
        endcase
    endfunction

    // flash_y only matters in FLASH, where both ambers blink together.
    function automatic lamps_t lamp_decode(input phase_e p, input logic flash_y);
        lamps_t l;
        l = '0;
        case (p)
            G1: begin
                l.g1 = 1'b1;
                l.r2 = 1'b1;
            end
            Y1: begin
                l.y1 = 1'b1;
                l.r2 = 1'b1;
            end
            G2: begin
                l.r1 = 1'b1;
                l.g2 = 1'b1;
            end
            Y2: begin
                l.r1 = 1'b1;
                l.y2 = 1'b1;
            end
            FLASH: begin
                l.y1 = flash_y;
                l.y2 = flash_y;
            end
            default: begin
                l.r1 = 1'b1;
                l.r2 = 1'b1;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase countdown: load on phase entry, pedestrian cut-down, tick decrement, expiry flag.
module phase_timer #(
    parameter int CNT_W   = 5,
    parameter int RST_VAL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             cut,
    input  logic [CNT_W-1:0] cut_val,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // Load beats cut, cut beats the tick decrement; a cut can only shorten.
    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (cut && (count_reg > cut_val)) begin
            count_next = cut_val;
        end else if (tick && (count_reg > CNT_W'(1))) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= CNT_W'(RST_VAL);
        end else begin
            count_reg <= count_next;
        end
    end

    assign count  = count_reg;
    assign expire = tick && (count_reg == CNT_W'(1));

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection sequencer: phase FSM, pedestrian arbitration, lamp and display decode.
// Optional night amber-flash mode is built in when NIGHT_FLASH_EN is defined.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int GREEN_T  = DEF_GREEN_T,
    parameter int YELLOW_T = DEF_YELLOW_T,
    parameter int ALLRED_T = DEF_ALLRED_T,
    parameter int PED_MIN  = DEF_PED_MIN
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             tick,
    input  logic [1:0]       ped_req,
`ifdef NIGHT_FLASH_EN
    input  logic             night,
`endif
    output logic [1:0]       ped_ack,
    output logic             LR1,
    output logic             LY1,
    output logic             LG1,
    output logic             LR2,
    output logic             LY2,
    output logic             LG2,
    output logic [CNT_W-1:0] Count,
    output logic             eLED01,
    output logic             eLED23,
    output logic [2:0]       phase
);

    localparam logic [CNT_W-1:0] GREEN_C  = CNT_W'(GREEN_T);
    localparam logic [CNT_W-1:0] YELLOW_C = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] ALLRED_C = CNT_W'(ALLRED_T);
    localparam logic [CNT_W-1:0] PED_C    = CNT_W'(PED_MIN);

    phase_e           state_reg;
    phase_e           state_next;
    logic [1:0]       pend_reg;
    logic [1:0]       pend_next;
    logic [1:0]       ack_reg;
    logic [1:0]       ack_next;
    lamps_t           lamps_reg;
    lamps_t           lamps_next;
    logic [1:0]       eled_reg;
    logic [1:0]       eled_next;
    logic             flash_y_reg;
    logic             flash_y_next;

    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             cut;
    logic             expire;
    logic [CNT_W-1:0] count;
    logic [1:0]       walk;
    logic [1:0]       enter;
    logic [1:0]       req_eff;

    function automatic logic [CNT_W-1:0] phase_time(input phase_e p);
        case (p)
            G1, G2:  return GREEN_C;
            Y1, Y2:  return YELLOW_C;
            FLASH:   return '0;
            default: return ALLRED_C;
        endcase
    endfunction

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        load_val   = ALLRED_C;
        if (state_reg == FLASH) begin
`ifdef NIGHT_FLASH_EN
            if (tick && !night) begin
                state_next = AR2;
                load       = 1'b1;
            end
`else
            state_next = AR2;
            load       = 1'b1;
`endif
        end else if (expire) begin
            state_next = next_phase(state_reg);
`ifdef NIGHT_FLASH_EN
            if (night) begin
                state_next = FLASH;
            end
`endif
            load     = 1'b1;
            load_val = phase_time(state_next);
        end
    end

    // Bit 0 crosses road 1 (walks during G2); bit 1 crosses road 2 (walks during G1).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ped
            localparam phase_e WALK_PH = (gi == 0) ? G2 : G1;
            assign walk[gi]      = (state_reg == WALK_PH);
            assign enter[gi]     = load && (state_next == WALK_PH);
            assign req_eff[gi]   = pend_reg[gi] | (ped_req[gi] & ~walk[gi]);
            assign pend_next[gi] = (state_reg == FLASH) ? pend_reg[gi] :
                                   enter[gi]            ? 1'b0 : req_eff[gi];
            assign ack_next[gi]  = enter[gi] & pend_reg[gi];
        end
    endgenerate

    assign cut = ((state_reg == G1) && req_eff[0]) || ((state_reg == G2) && req_eff[1]);

    always_comb begin
        flash_y_next = 1'b0;
        if (state_next == FLASH) begin
            if (state_reg != FLASH) begin
                flash_y_next = 1'b1;
            end else if (tick) begin
                flash_y_next = ~flash_y_reg;
            end else begin
                flash_y_next = flash_y_reg;
            end
        end
    end

    // Decode from the next state so lamps, Count and phase all change on the same edge.
    always_comb begin
        lamps_next   = lamp_decode(state_next, flash_y_next);
        eled_next[0] = (state_next == G1) || (state_next == Y1);
        eled_next[1] = (state_next == G2) || (state_next == Y2);
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_reg   <= AR2;
            pend_reg    <= '0;
            ack_reg     <= '0;
            lamps_reg   <= '{r1: 1'b1, r2: 1'b1, default: 1'b0};
            eled_reg    <= '0;
            flash_y_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pend_reg    <= pend_next;
            ack_reg     <= ack_next;
            lamps_reg   <= lamps_next;
            eled_reg    <= eled_next;
            flash_y_reg <= flash_y_next;
        end
    end

    phase_timer #(
        .CNT_W  (CNT_W),
        .RST_VAL(ALLRED_T)
    ) u_timer (
        .clk     (clk1),
        .rst_n   (rst),
        .tick    (tick),
        .load    (load),
        .load_val(load_val),
        .cut     (cut),
        .cut_val (PED_C),
        .count   (count),
        .expire  (expire)
    );

    assign ped_ack = ack_reg;
    assign LR1     = lamps_reg.r1;
    assign LY1     = lamps_reg.y1;
    assign LG1     = lamps_reg.g1;
    assign LR2     = lamps_reg.r2;
    assign LY2     = lamps_reg.y2;
    assign LG2     = lamps_reg.g2;
    assign Count   = count;
    assign eLED01  = eled_reg[0];
    assign eLED23  = eled_reg[1];
    assign phase   = state_reg;

endmodule
